// File: rtl/spi_slave_mode.sv
// SPI slave, all four CPOL/CPHA modes, multi-word frames, TX holding register.
// Optional status counters are enabled by defining SPI_SLAVE_MODE_STATUS_EN.
module spi_slave_mode #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = '1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  ss,
  input  logic                  sck,
  input  logic                  mosi,
  output wire                   miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  underrun,
  output logic                  frame_abort,
  output logic                  busy
`ifdef SPI_SLAVE_MODE_STATUS_EN
  ,
  input  logic                  clr_cnt,
  output logic [15:0]           err_cnt,
  output logic [15:0]           word_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;

  state_t                  state, state_next;
  logic [SYNC_STAGES-1:0]  ss_sync, sck_sync, mosi_sync;
  logic                    ss_d, sck_d;
  logic                    ss_s, sck_s, mosi_s, ss_fall;
  logic                    cpol_l, cpha_l;
  logic [CNT_W-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0]   shift_reg, hold_data, reload_word;
  logic                    hold_full, miso_q;
  logic                    lead_edge, trail_edge, last_bit;
  logic                    sample_en, shift_en, reload, abort;

  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ss_fall = ss_d && !ss_s;

  // Leading edge leaves the latched idle level, trailing edge returns to it.
  assign lead_edge  = (sck_d == cpol_l) && (sck_s != cpol_l);
  assign trail_edge = (sck_d != cpol_l) && (sck_s == cpol_l);
  assign last_bit   = (bit_cnt == LAST_BIT);

  // A word already in the holding register wins; otherwise a same-cycle
  // handshake passes straight through, else the idle pattern goes out.
  assign reload_word = hold_full ? hold_data : (tx_valid ? tx_data : IDLE_WORD);

  assign tx_ready = !hold_full;
  assign busy     = (state == ACTIVE);
  assign miso     = ss ? 1'bz : miso_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      ss_d      <= 1'b1;
      sck_d     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its pre-edge neighbour.
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_d      <= ss_s;
      sck_d     <= sck_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_next = state;
    sample_en  = 1'b0;
    shift_en   = 1'b0;
    reload     = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE:   if (ss_fall) state_next = LOAD;
      LOAD: begin
        reload     = 1'b1;
        state_next = ACTIVE;
      end
      ACTIVE: begin
        if (ss_s) begin
          state_next = IDLE;
          abort      = (bit_cnt != '0);
        end else begin
          sample_en = cpha_l ? trail_edge : lead_edge;
          shift_en  = cpha_l ? lead_edge  : trail_edge;
          reload    = sample_en && last_bit;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpol_l      <= 1'b0;
      cpha_l      <= 1'b0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      hold_data   <= '0;
      hold_full   <= 1'b0;
      miso_q      <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      underrun    <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      underrun    <= 1'b0;
      frame_abort <= abort;

      if (state == IDLE) begin
        cpol_l  <= cpol;
        cpha_l  <= cpha;
        bit_cnt <= '0;
      end

      if (sample_en) begin
        if (last_bit) begin
          bit_cnt  <= '0;
          rx_data  <= {shift_reg[DATA_WIDTH-2:0], mosi_s};
          rx_valid <= 1'b1;
        end else begin
          bit_cnt   <= bit_cnt + 1'b1;
          shift_reg <= {shift_reg[DATA_WIDTH-2:0], mosi_s};
        end
      end

      if (shift_en) miso_q <= shift_reg[DATA_WIDTH-1];

      if (reload) begin
        shift_reg <= reload_word;
        hold_full <= 1'b0;
        underrun  <= !hold_full && !tx_valid;
        if (state == LOAD) miso_q <= reload_word[DATA_WIDTH-1];
      end else if (tx_valid && !hold_full) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

`ifdef SPI_SLAVE_MODE_STATUS_EN
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  assign err_inc = {1'b0, underrun} + {1'b0, frame_abort};
  assign err_sum = {1'b0, err_cnt} + {15'd0, err_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt  <= '0;
      word_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      if (ss_fall)                         word_cnt <= '0;
      else if (rx_valid && word_cnt != '1) word_cnt <= word_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_mode.sv
// Directed bench for spi_slave_mode: acts as SPI master in all four modes and
// checks received/transmitted words and status strobes with immediate assertions.
module tb_spi_slave_mode;

  localparam int HALF = 8;   // clk cycles per sck half-period
  localparam int GAP  = 8;   // ss edge to first/after last sck edge

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpol, cpha, ss, sck, mosi;
  wire        miso;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, underrun, frame_abort, busy;
`ifdef SPI_SLAVE_MODE_STATUS_EN
  logic        clr_cnt;
  logic [15:0] err_cnt, word_cnt;
`endif

  pulldown (miso);

  spi_slave_mode #(.DATA_WIDTH(8), .SYNC_STAGES(2), .IDLE_WORD(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .ss(ss), .sck(sck),
    .mosi(mosi), .miso(miso), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .underrun(underrun), .frame_abort(frame_abort), .busy(busy)
`ifdef SPI_SLAVE_MODE_STATUS_EN
    , .clr_cnt(clr_cnt), .err_cnt(err_cnt), .word_cnt(word_cnt)
`endif
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Strobe monitor: counts pulses and logs received words.
  int         rxv_cnt = 0, und_cnt = 0, abort_cnt = 0, back2back = 0;
  logic       rxv_prev = 1'b0;
  logic [7:0] rx_hist [0:63];

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_hist[rxv_cnt % 64] = rx_data;
      rxv_cnt++;
      if (rxv_prev) back2back++;
    end
    if (underrun)    und_cnt++;
    if (frame_abort) abort_cnt++;
    rxv_prev = rx_valid;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic m_cpol, m_cpha;

  task automatic set_mode(input logic p, input logic h);
    m_cpol = p; m_cpha = h;
    cpol = p; cpha = h; sck = p;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_begin();
    ss = 1'b0;
    repeat (GAP) @(negedge clk);
    check("busy_in_frame", busy, 1);
  endtask

  task automatic frame_end();
    repeat (HALF) @(negedge clk);
    ss = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (!m_cpha) begin
        mosi = tx[i];
        repeat (HALF) @(negedge clk);
        rx[i] = miso; sck = ~m_cpol;
        repeat (HALF) @(negedge clk);
        sck = m_cpol;
      end else begin
        sck = ~m_cpol; mosi = tx[i];
        repeat (HALF) @(negedge clk);
        rx[i] = miso; sck = m_cpol;
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  task automatic push_tx(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("tx_ready_wait", tx_ready, 1);
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] m_rx, m_rx2, m_rx3;
    int r0, u0, a0;

    rst_n = 1'b0; ss = 1'b1; sck = 1'b0; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0;
    tx_data = '0; tx_valid = 1'b0;
`ifdef SPI_SLAVE_MODE_STATUS_EN
    clr_cnt = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_frame_abort", frame_abort, 0);
    check("rst_miso_hiz", miso, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Mode 0: preload A5 (plus a follow-on word so the boundary never underruns).
    r0 = rxv_cnt; u0 = und_cnt;
    fork
      begin
        set_mode(1'b0, 1'b0);
        frame_begin();
        xfer_bits(8'h3C, 8, m_rx);
        frame_end();
      end
      begin
        push_tx(8'hA5);
        push_tx(8'h00);
      end
    join
    check("m0_master_rx", m_rx, 8'hA5);
    check("m0_rx_data", rx_data, 8'h3C);
    check("m0_rx_pulses", rxv_cnt - r0, 1);
    check("m0_underrun", und_cnt - u0, 0);

    // Mode 3: three-word frame, words fed as the holding register empties.
    r0 = rxv_cnt; u0 = und_cnt;
    fork
      begin
        set_mode(1'b1, 1'b1);
        frame_begin();
        xfer_bits(8'hC1, 8, m_rx);
        xfer_bits(8'hC2, 8, m_rx2);
        xfer_bits(8'hC3, 8, m_rx3);
        frame_end();
      end
      begin
        push_tx(8'h11);
        push_tx(8'h22);
        push_tx(8'h33);
        push_tx(8'h44);
      end
    join
    check("m3_master_rx0", m_rx, 8'h11);
    check("m3_master_rx1", m_rx2, 8'h22);
    check("m3_master_rx2", m_rx3, 8'h33);
    check("m3_rx_pulses", rxv_cnt - r0, 3);
    check("m3_rx_word0", rx_hist[r0 % 64], 8'hC1);
    check("m3_rx_word1", rx_hist[(r0 + 1) % 64], 8'hC2);
    check("m3_rx_word2", rx_hist[(r0 + 2) % 64], 8'hC3);
    check("m3_underrun", und_cnt - u0, 0);

    // Mode 1: nothing queued at LOAD -> idle word and one underrun.
    r0 = rxv_cnt; u0 = und_cnt;
    fork
      begin
        set_mode(1'b0, 1'b1);
        frame_begin();
        xfer_bits(8'h00, 8, m_rx);
        frame_end();
      end
      begin
        int n = 0;
        while (und_cnt == u0 && n < 500) begin
          @(negedge clk);
          n++;
        end
        check("m1_underrun_seen", und_cnt != u0, 1);
        push_tx(8'h77);
      end
    join
    check("m1_master_rx", m_rx, 8'hFF);
    check("m1_underrun_once", und_cnt - u0, 1);
    check("m1_rx_data", rx_data, 8'h00);

    // Mode 2: ss raised after 5 bits aborts the word.
    r0 = rxv_cnt; a0 = abort_cnt;
    set_mode(1'b1, 1'b0);
    frame_begin();
    xfer_bits(8'hF0, 5, m_rx);
    frame_end();
    check("m2_abort_pulse", abort_cnt - a0, 1);
    check("m2_no_rx_valid", rxv_cnt - r0, 0);
    check("m2_rx_data_held", rx_data, 8'h00);
    check("m2_idle_after_abort", busy, 0);

    r0 = rxv_cnt; a0 = abort_cnt;
    fork
      begin
        frame_begin();
        xfer_bits(8'h96, 8, m_rx);
        frame_end();
      end
      begin
        push_tx(8'h69);
        push_tx(8'h00);
      end
    join
    check("m2_master_rx", m_rx, 8'h69);
    check("m2_rx_data", rx_data, 8'h96);
    check("m2_rx_pulses", rxv_cnt - r0, 1);
    check("m2_no_abort", abort_cnt - a0, 0);

    // Reset asserted mid-word.
    set_mode(1'b0, 1'b0);
    frame_begin();
    xfer_bits(8'hAA, 3, m_rx);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rx_data", rx_data, 0);
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_underrun", underrun, 0);
    check("mid_rst_miso_q", miso, 1);
    ss = 1'b1; sck = 1'b0;
    #1;
    check("mid_rst_miso_hiz", miso, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    r0 = rxv_cnt;
    fork
      begin
        set_mode(1'b0, 1'b0);
        frame_begin();
        xfer_bits(8'h5A, 8, m_rx);
        frame_end();
      end
      begin
        push_tx(8'hC3);
        push_tx(8'h00);
      end
    join
    check("post_rst_master_rx", m_rx, 8'hC3);
    check("post_rst_rx_data", rx_data, 8'h5A);
    check("post_rst_rx_pulses", rxv_cnt - r0, 1);

`ifdef SPI_SLAVE_MODE_STATUS_EN
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    set_mode(1'b0, 1'b0);
    frame_begin();
    xfer_bits(8'h00, 3, m_rx);
    frame_end();
    check("st_err_cnt_2", err_cnt, 2);
    check("st_word_cnt_0", word_cnt, 0);
    frame_begin();
    xfer_bits(8'h12, 8, m_rx);
    frame_end();
    check("st_err_cnt_4", err_cnt, 4);
    check("st_word_cnt_1", word_cnt, 1);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    check("st_clr_err", err_cnt, 0);
    check("st_clr_word", word_cnt, 0);
`endif

    check("rx_valid_never_back_to_back", back2back, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
